// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the ID-side
// hazard / trap controller of the 5-stage MIPS core.
package pipe_ctrl_pkg;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_J   = 3'd2;
    localparam logic [2:0] PC_SEL_JR  = 3'd3;
    localparam logic [2:0] PC_SEL_IRQ = 3'd4;
    localparam logic [2:0] PC_SEL_EXC = 3'd5;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam logic [4:0] REG_K0 = 5'd26;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_KWAIT
    } state_t;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller:
// ID/EX status in, PC / pipeline-register control and IRQ state out.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_IRQ = 4,
    parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    logic [31:0]        id_instr;
    logic               id_valid;
    logic               in_kernel;
    logic               ex_memrd;
    logic [4:0]         ex_rt;
    logic               ex_branch_taken;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [2:0]         pc_sel;
    logic               pc_we;
    logic               ifid_we;
    logic               flush_ifid;
    logic               flush_idex;
    logic               trap_wr;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [IRQ_W-1:0]   irq_id;
    logic               exc_illegal;

    modport master (
        output id_instr, id_valid, in_kernel,
        output ex_memrd, ex_rt, ex_branch_taken,
        output irq, irq_mask, irq_clr,
        input  pc_sel, pc_we, ifid_we,
        input  flush_ifid, flush_idex, trap_wr,
        input  irq_pending, irq_id, exc_illegal
    );

    modport slave (
        input  id_instr, id_valid, in_kernel,
        input  ex_memrd, ex_rt, ex_branch_taken,
        input  irq, irq_mask, irq_clr,
        output pc_sel, pc_we, ifid_we,
        output flush_ifid, flush_idex, trap_wr,
        output irq_pending, irq_id, exc_illegal
    );

endinterface

// File: rtl/pipe_hazard_ctrl_insn_class.sv
// Combinational classifier for the ID instruction: legality,
// rt usage, jump kinds and source register fields.
module insn_class
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output logic        uses_rt,
    output logic        is_j,
    output logic        is_jr,
    output logic [4:0]  rs,
    output logic [4:0]  rt
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       fn_ok;
    logic       unused_bits;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign unused_bits = ^instr[15:6];

    assign fn_ok = fn inside {FN_SLL, FN_SRL, FN_SRA,
                              FN_JR, FN_JALR,
                              [FN_ADD:FN_NOR], FN_SLT};

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            op == OP_RTYPE: legal = fn_ok;
            op inside {[OP_REGIMM:OP_ORI], OP_LUI,
                       OP_LW, OP_SW}: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign uses_rt = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    assign is_j    = op inside {OP_J, OP_JAL};
    assign is_jr   = (op == OP_RTYPE) && (fn inside {FN_JR, FN_JALR});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-side pipeline controller: load-use stalls, redirects,
// illegal-instruction traps and edge-captured interrupts.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int LOAD_LAT = 1,
    parameter int IRQ_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               ret_k_q, ret_k_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [IRQ_W-1:0]   irq_id_q, irq_id_d;

    logic       legal, uses_rt, is_j, is_jr;
    logic [4:0] rs, rt;

    insn_class u_cls (
        .instr   (bus.id_instr),
        .legal   (legal),
        .uses_rt (uses_rt),
        .is_j    (is_j),
        .is_jr   (is_jr),
        .rs      (rs),
        .rt      (rt)
    );

    logic [NUM_IRQ-1:0] unmasked;
    logic hazard, take_exc, take_irq, kexit, stalling;

    assign unmasked = pend_q & ~bus.irq_mask;
    assign stalling = state_q == ST_STALL;
    assign hazard   = bus.ex_memrd && bus.ex_rt != 5'd0
                   && bus.id_valid
                   && (bus.ex_rt == rs
                       || (uses_rt && bus.ex_rt == rt));
    assign take_exc = bus.id_valid && !legal && !stalling;
    assign take_irq = state_q == ST_RUN && bus.id_valid
                   && !bus.in_kernel && |unmasked;
    assign kexit    = state_q == ST_KWAIT && bus.id_valid
                   && !bus.in_kernel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            ret_k_q    <= 1'b0;
            irq_prev_q <= '0;
            pend_q     <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ret_k_q    <= ret_k_d;
            irq_id_q   <= irq_id_d;
            irq_prev_q <= bus.irq;
            pend_q     <= (pend_q & ~bus.irq_clr)
                        | (bus.irq & ~irq_prev_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ret_k_d  = ret_k_q;
        irq_id_d = irq_id_q;
        if (bus.ex_branch_taken) begin
            cnt_d = 2'd0;
            if (stalling) state_d = ret_k_q ? ST_KWAIT : ST_RUN;
        end else if (take_exc) begin
            state_d = ST_KWAIT;
        end else if (take_irq) begin
            state_d  = ST_KWAIT;
            irq_id_d = IRQ_W'(lowest_idx(8'(unmasked)));
        end else if (stalling) begin
            // cnt counts the stall cycles still owed after this one
            cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = ret_k_q ? ST_KWAIT : ST_RUN;
        end else if (hazard) begin
            cnt_d = CNT_INIT;
            if (LOAD_LAT > 1) begin
                state_d = ST_STALL;
                ret_k_d = state_q == ST_KWAIT;
            end
        end else if (kexit) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        bus.pc_sel      = PC_SEL_SEQ;
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.flush_ifid  = 1'b0;
        bus.flush_idex  = 1'b0;
        bus.trap_wr     = 1'b0;
        bus.exc_illegal = 1'b0;
        if (bus.ex_branch_taken) begin
            bus.pc_sel     = PC_SEL_BR;
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
        end else if (take_exc) begin
            bus.pc_sel      = PC_SEL_EXC;
            bus.trap_wr     = 1'b1;
            bus.exc_illegal = 1'b1;
            bus.flush_ifid  = 1'b1;
        end else if (take_irq) begin
            bus.pc_sel     = PC_SEL_IRQ;
            bus.trap_wr    = 1'b1;
            bus.flush_ifid = 1'b1;
        end else if (stalling || hazard) begin
            bus.pc_we      = 1'b0;
            bus.ifid_we    = 1'b0;
            bus.flush_idex = 1'b1;
        end else if (bus.id_valid && is_j) begin
            bus.pc_sel     = PC_SEL_J;
            bus.flush_ifid = 1'b1;
        end else if (bus.id_valid && is_jr) begin
            bus.pc_sel     = PC_SEL_JR;
            bus.flush_ifid = 1'b1;
        end
    end

    assign bus.irq_pending = pend_q;
    assign bus.irq_id      = irq_id_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: behavioural model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int NIRQ     = 4;
    localparam int LOAD_LAT = 3;

    localparam int A_SEQ   = 0;
    localparam int A_BR    = 1;
    localparam int A_EXC   = 2;
    localparam int A_IRQ   = 3;
    localparam int A_STALL = 4;
    localparam int A_HAZ   = 5;
    localparam int A_J     = 6;
    localparam int A_JR    = 7;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] ADD = {6'h00, 5'd8, 5'd8, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NUM_IRQ(NIRQ)) b();

    pipe_hazard_ctrl #(
        .NUM_IRQ  (NIRQ),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        chk_en = 1'b0;
    int        m_stall = 0;
    bit        m_kw = 1'b0;
    bit [3:0]  m_pend = '0;
    bit [3:0]  m_prev = '0;
    int        m_id = 0;
    int        m_act = A_SEQ;
    int        m_low = 0;

    function automatic bit m_legal(logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00)
            return fn == 6'h00 || fn == 6'h02 || fn == 6'h03
                || fn == 6'h08 || fn == 6'h09
                || (fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a;
        return (op >= 6'h01 && op <= 6'h0d) || op == 6'h0f
            || op == 6'h23 || op == 6'h2b;
    endfunction

    function automatic int f_low();
        for (int i = 0; i < NIRQ; i++)
            if (m_pend[i] && !b.irq_mask[i]) return i;
        return 0;
    endfunction

    function automatic int f_act();
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        bit uses_rt, haz, any_irq;
        op = b.id_instr[31:26];
        fn = b.id_instr[5:0];
        rs = b.id_instr[25:21];
        rt = b.id_instr[20:16];
        uses_rt = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b;
        haz = b.ex_memrd && b.ex_rt != 0 && b.id_valid
           && (b.ex_rt == rs || (uses_rt && b.ex_rt == rt));
        any_irq = (m_pend & ~b.irq_mask) != 0;
        if (b.ex_branch_taken) return A_BR;
        if (b.id_valid && !m_legal(b.id_instr) && m_stall == 0)
            return A_EXC;
        if (!m_kw && m_stall == 0 && b.id_valid && !b.in_kernel && any_irq)
            return A_IRQ;
        if (m_stall > 0) return A_STALL;
        if (haz) return A_HAZ;
        if (b.id_valid && (op == 6'h02 || op == 6'h03)) return A_J;
        if (b.id_valid && op == 6'h00 && (fn == 6'h08 || fn == 6'h09))
            return A_JR;
        return A_SEQ;
    endfunction

    task automatic check_cycle();
        int a = f_act();
        logic [2:0] e_sel = 3'd0;
        bit e_we = 1'b1, e_fi = 1'b0, e_fx = 1'b0;
        bit e_trap = 1'b0, e_exc = 1'b0;
        case (a)
            A_BR:  begin e_sel = 3'd1; e_fi = 1; e_fx = 1; end
            A_EXC: begin e_sel = 3'd5; e_fi = 1; e_trap = 1; e_exc = 1; end
            A_IRQ: begin e_sel = 3'd4; e_fi = 1; e_trap = 1; end
            A_STALL, A_HAZ: begin e_we = 0; e_fx = 1; end
            A_J:   begin e_sel = 3'd2; e_fi = 1; end
            A_JR:  begin e_sel = 3'd3; e_fi = 1; end
            default: ;
        endcase
        chk("cyc_pc_sel", 32'(b.pc_sel), 32'(e_sel));
        chk("cyc_pc_we", 32'(b.pc_we), 32'(e_we));
        chk("cyc_ifid_we", 32'(b.ifid_we), 32'(e_we));
        chk("cyc_flush_ifid", 32'(b.flush_ifid), 32'(e_fi));
        chk("cyc_flush_idex", 32'(b.flush_idex), 32'(e_fx));
        chk("cyc_trap_wr", 32'(b.trap_wr), 32'(e_trap));
        chk("cyc_exc_illegal", 32'(b.exc_illegal), 32'(e_exc));
        chk("cyc_pending", 32'(b.irq_pending), 32'(m_pend));
        chk("cyc_irq_id", 32'(b.irq_id), 32'(m_id));
    endtask

    always @(negedge clk) begin
        if (chk_en) check_cycle();
        m_act <= f_act();
        m_low <= f_low();
    end

    always @(posedge clk) begin
        if (rst) begin
            m_stall <= 0;
            m_kw    <= 1'b0;
            m_pend  <= '0;
            m_prev  <= '0;
            m_id    <= 0;
            chk_en  <= 1'b1;
        end else begin
            case (m_act)
                A_BR:    m_stall <= 0;
                A_EXC:   m_kw <= 1'b1;
                A_IRQ:   begin m_kw <= 1'b1; m_id <= m_low; end
                A_STALL: m_stall <= m_stall - 1;
                A_HAZ:   m_stall <= LOAD_LAT - 1;
                default:
                    if (m_kw && b.id_valid && !b.in_kernel) m_kw <= 1'b0;
            endcase
            for (int i = 0; i < NIRQ; i++)
                m_pend[i] <= (m_pend[i] && !b.irq_clr[i])
                          || (b.irq[i] && !m_prev[i]);
            m_prev <= b.irq;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        b.id_instr        = NOP;
        b.id_valid        = 1'b1;
        b.in_kernel       = 1'b0;
        b.ex_memrd        = 1'b0;
        b.ex_rt           = 5'd0;
        b.ex_branch_taken = 1'b0;
        b.irq             = '0;
        b.irq_mask        = '0;
        b.irq_clr         = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    int nstall;

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        mid();
        chk("rst_pc_sel", 32'(b.pc_sel), 0);
        chk("rst_pc_we", 32'(b.pc_we), 1);
        chk("rst_flags", 32'({b.flush_ifid, b.flush_idex,
                              b.trap_wr, b.exc_illegal}), 0);
        chk("rst_pending", 32'(b.irq_pending), 0);

        // load-use: add $9,$8,$8 behind lw $8
        nstall = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                b.ex_memrd = 1'b1; b.ex_rt = 5'd8; b.id_instr = ADD;
            end else begin
                b.ex_memrd = 1'b0; b.ex_rt = 5'd0;
            end
            mid();
            if (!b.pc_we) nstall++;
            if (k == 0) begin
                chk("lu_pc_we", 32'(b.pc_we), 0);
                chk("lu_flush_idex", 32'(b.flush_idex), 1);
            end
        end
        chk("lu_len", nstall, LOAD_LAT);

        tick();
        b.ex_memrd = 1'b1; b.ex_rt = 5'd0;
        b.id_instr = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
        mid();
        chk("lu_rt0", 32'(b.pc_we), 1);
        tick();
        b.ex_rt = 5'd8;
        b.id_instr = {6'h23, 5'd0, 5'd8, 16'd0};
        mid();
        chk("lu_lw_rt", 32'(b.pc_we), 1);
        tick();
        b.id_instr = {6'h2b, 5'd0, 5'd8, 16'd0};
        mid();
        chk("lu_sw_rt", 32'(b.pc_we), 0);
        tick();
        b.ex_memrd = 1'b0; b.ex_rt = 5'd0;
        repeat (3) tick();

        // reset in the middle of a stall
        idle();
        b.irq = 4'b0001;
        tick();
        b.irq = 4'b0000; b.in_kernel = 1'b1;
        b.ex_memrd = 1'b1; b.ex_rt = 5'd8; b.id_instr = ADD;
        tick();
        b.ex_memrd = 1'b0; b.ex_rt = 5'd0;
        tick();
        rst = 1'b1;
        mid();
        chk("mid_stall_pc_we", 32'(b.pc_we), 0);
        chk("pre_rst_pending", 32'(b.irq_pending), 1);
        tick();
        rst = 1'b0; b.in_kernel = 1'b0;
        mid();
        chk("post_rst_pc_we", 32'(b.pc_we), 1);
        chk("post_rst_flush_idex", 32'(b.flush_idex), 0);
        chk("post_rst_pending", 32'(b.irq_pending), 0);

        // interrupts: lowest unmasked, KWAIT blocking, exit latency
        tick();
        idle();
        b.irq = 4'b0110; b.irq_mask = 4'b0010;
        mid();
        chk("irq_edge_sel", 32'(b.pc_sel), 0);
        tick();
        mid();
        chk("irq_sel", 32'(b.pc_sel), 4);
        chk("irq_trap", 32'(b.trap_wr), 1);
        chk("irq_pend", 32'(b.irq_pending), 32'h6);
        tick();
        b.in_kernel = 1'b1;
        mid();
        chk("irq_id", 32'(b.irq_id), 2);
        tick();
        b.irq = 4'b0000;
        tick();
        b.irq = 4'b1000;
        tick();
        b.irq_clr = 4'b0110;
        mid();
        chk("kw_no_trap", 32'(b.pc_sel), 0);
        tick();
        b.irq_clr = '0; b.in_kernel = 1'b0;
        mid();
        chk("clr_pend", 32'(b.irq_pending), 32'h8);
        chk("kexit_no_trap", 32'(b.trap_wr), 0);
        tick();
        mid();
        chk("irq2_sel", 32'(b.pc_sel), 4);
        tick();
        b.in_kernel = 1'b1;
        mid();
        chk("irq2_id", 32'(b.irq_id), 3);

        // set and clear in the same cycle
        do_reset();
        tick();
        b.irq = 4'b0010; b.irq_clr = 4'b0010; b.irq_mask = 4'b1111;
        tick();
        b.irq_clr = '0;
        mid();
        chk("setclr_pend1", 32'(b.irq_pending[1]), 1);

        // illegal instructions
        do_reset();
        tick();
        b.id_instr = ILL;
        mid();
        chk("ill_sel", 32'(b.pc_sel), 5);
        chk("ill_exc", 32'(b.exc_illegal), 1);
        chk("ill_trap", 32'(b.trap_wr), 1);
        chk("ill_flush_ifid", 32'(b.flush_ifid), 1);
        tick();
        b.in_kernel = 1'b1;
        b.id_instr = {6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 6'h18};
        mid();
        chk("ill_mult_kw", 32'(b.exc_illegal), 1);
        tick();
        b.id_instr = NOP; b.irq = 4'b0001;
        tick();
        b.in_kernel = 1'b0;
        mid();
        chk("ill_kwait_block", 32'(b.trap_wr), 0);
        tick();
        mid();
        chk("ill_then_irq", 32'(b.pc_sel), 4);

        // illegal arriving during a stall
        do_reset();
        tick();
        b.ex_memrd = 1'b1; b.ex_rt = 5'd8; b.id_instr = ADD;
        mid();
        chk("st_ill_pc_we", 32'(b.pc_we), 0);
        tick();
        b.ex_memrd = 1'b0; b.ex_rt = 5'd0; b.id_instr = ILL;
        mid();
        chk("st_ill_hold1", 32'(b.exc_illegal), 0);
        tick();
        mid();
        chk("st_ill_hold2", 32'(b.exc_illegal), 0);
        tick();
        mid();
        chk("st_ill_trap", 32'(b.exc_illegal), 1);
        chk("st_ill_sel", 32'(b.pc_sel), 5);

        // branch aborts a stall; pending interrupt follows
        do_reset();
        tick();
        b.in_kernel = 1'b1; b.irq = 4'b0001;
        b.ex_memrd = 1'b1; b.ex_rt = 5'd8; b.id_instr = ADD;
        mid();
        chk("br_pre_pc_we", 32'(b.pc_we), 0);
        tick();
        b.ex_memrd = 1'b0; b.ex_rt = 5'd0;
        b.in_kernel = 1'b0; b.ex_branch_taken = 1'b1;
        mid();
        chk("br_sel", 32'(b.pc_sel), 1);
        chk("br_flushes", 32'({b.flush_ifid, b.flush_idex}), 3);
        chk("br_pc_we", 32'(b.pc_we), 1);
        tick();
        b.ex_branch_taken = 1'b0;
        mid();
        chk("br_irq_sel", 32'(b.pc_sel), 4);
        chk("br_irq_trap", 32'(b.trap_wr), 1);

        // jumps
        do_reset();
        tick();
        b.id_instr = {6'h02, 26'h10};
        mid();
        chk("j_sel", 32'(b.pc_sel), 2);
        chk("j_flush", 32'(b.flush_ifid), 1);
        tick();
        b.id_instr = {6'h00, 5'd31, 5'd0, 5'd31, 5'd0, 6'h09};
        mid();
        chk("jalr_sel", 32'(b.pc_sel), 3);
        tick();
        b.id_valid = 1'b0;
        mid();
        chk("jalr_invalid_sel", 32'(b.pc_sel), 0);
        tick();
        idle();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
